// File: rtl/lea_cu_gen.sv
// Control unit for a keypad-driven LEA encrypt/decrypt demo: digit entry, edge
// detection, core start/done handshake, wrong-key lockout and LCD screen codes.
module lea_cu_gen #(
  parameter int unsigned TEXT_DIGITS = 8,
  parameter int unsigned KEY_DIGITS  = 8,
  parameter int unsigned MAX_TRIES   = 3,
  localparam int unsigned MAX_DIGITS = (TEXT_DIGITS > KEY_DIGITS) ? TEXT_DIGITS : KEY_DIGITS,
  localparam int unsigned CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          star,
  input  logic          sharp,
  input  logic          digit_valid,
  input  logic [3:0]    digit,
  input  logic          key_match,
  input  logic          core_done,
  output logic [2:0]    LCD_addr,
  output logic          chk_text,
  output logic          chk_key,
  output logic          star_out,
  output logic          sharp_out,
  output logic          wr_text,
  output logic          wr_key,
  output logic [CW-1:0] wr_idx,
  output logic [3:0]    wr_data,
  output logic          core_start,
  output logic          core_mode,
  output logic          locked
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [3:0] {
    S_START, S_IN_TEXT, S_IN_KEY, S_ENC_RUN, S_ENC_OK,
    S_SHOW_CT, S_IN_KEY_DEC, S_DEC_RUN, S_DEC_OK, S_LOCKED
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, limit;
  logic [TW-1:0] tries, tries_d, tries_inc;
  logic          star_q, sharp_q, primed;
  logic          star_p, sharp_p, star_only, sharp_only, full;
  logic          do_wr, do_start;

  logic [2:0]    lcd_d;
  logic          chk_text_d, chk_key_d, wr_text_d, wr_key_d;
  logic [CW-1:0] wr_idx_d;
  logic [3:0]    wr_data_d;
  logic          core_mode_d, locked_d;

  // primed masks the first cycle after reset so a button held through reset
  // must be released and pressed again before it counts
  assign star_p     = star  & ~star_q  & primed;
  assign sharp_p    = sharp & ~sharp_q & primed;
  assign star_only  = star_p & ~sharp_p;
  assign sharp_only = sharp_p & ~star_p;
  assign limit      = (state == S_IN_TEXT) ? CW'(TEXT_DIGITS) : CW'(KEY_DIGITS);
  assign full       = (cnt == limit);
  assign tries_inc  = tries + TW'(1);

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_START;
      cnt        <= '0;
      tries      <= '0;
      star_q     <= 1'b0;
      sharp_q    <= 1'b0;
      primed     <= 1'b0;
      LCD_addr   <= '0;
      chk_text   <= 1'b0;
      chk_key    <= 1'b0;
      star_out   <= 1'b0;
      sharp_out  <= 1'b0;
      wr_text    <= 1'b0;
      wr_key     <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      core_start <= 1'b0;
      core_mode  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      tries      <= tries_d;
      star_q     <= star;
      sharp_q    <= sharp;
      primed     <= 1'b1;
      LCD_addr   <= lcd_d;
      chk_text   <= chk_text_d;
      chk_key    <= chk_key_d;
      star_out   <= star_p;
      sharp_out  <= sharp_p;
      wr_text    <= wr_text_d;
      wr_key     <= wr_key_d;
      wr_idx     <= wr_idx_d;
      wr_data    <= wr_data_d;
      core_start <= do_start;
      core_mode  <= core_mode_d;
      locked     <= locked_d;
    end
  end

  // Next state; simultaneous star+sharp is treated as no button at all
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    tries_d  = tries;
    do_wr    = 1'b0;
    do_start = 1'b0;
    case (state)
      S_START: begin
        if (star_only) begin
          state_d = S_IN_TEXT;
          cnt_d   = '0;
        end
      end
      S_IN_TEXT, S_IN_KEY, S_IN_KEY_DEC: begin
        if (star_only) begin
          cnt_d = '0;
        end else if (sharp_only) begin
          if (full) begin
            cnt_d = '0;
            if (state == S_IN_TEXT) begin
              state_d = S_IN_KEY;
            end else if (state == S_IN_KEY) begin
              state_d  = S_ENC_RUN;
              do_start = 1'b1;
            end else if (key_match) begin
              state_d  = S_DEC_RUN;
              do_start = 1'b1;
            end else begin
              tries_d = tries_inc;
              if (tries_inc == TW'(MAX_TRIES)) state_d = S_LOCKED;
            end
          end
        end else if (!star_p && !sharp_p && digit_valid && !full) begin
          do_wr = 1'b1;
          cnt_d = cnt + CW'(1);
        end
      end
      S_ENC_RUN: if (core_done) state_d = S_ENC_OK;
      S_ENC_OK:  if (star_only) state_d = S_SHOW_CT;
      S_SHOW_CT: begin
        if (star_only) begin
          state_d = S_IN_KEY_DEC;
          cnt_d   = '0;
        end
      end
      S_DEC_RUN: if (core_done) state_d = S_DEC_OK;
      S_DEC_OK: begin
        if (star_only) begin
          state_d = S_START;
          tries_d = '0;
        end
      end
      default: state_d = state;
    endcase
  end

  // Output values loaded into the output registers
  always_comb begin
    lcd_d = 3'd0;
    case (state_d)
      S_START:      lcd_d = 3'd0;
      S_IN_TEXT:    lcd_d = 3'd1;
      S_IN_KEY:     lcd_d = 3'd2;
      S_ENC_RUN:    lcd_d = 3'd2;
      S_ENC_OK:     lcd_d = 3'd3;
      S_SHOW_CT:    lcd_d = 3'd4;
      S_IN_KEY_DEC: lcd_d = 3'd5;
      S_DEC_RUN:    lcd_d = 3'd5;
      S_DEC_OK:     lcd_d = 3'd6;
      S_LOCKED:     lcd_d = 3'd7;
      default:      lcd_d = 3'd0;
    endcase
    chk_text_d  = (state_d == S_IN_TEXT) && (cnt_d == CW'(TEXT_DIGITS));
    chk_key_d   = ((state_d == S_IN_KEY) || (state_d == S_IN_KEY_DEC)) &&
                  (cnt_d == CW'(KEY_DIGITS));
    wr_text_d   = do_wr && (state == S_IN_TEXT);
    wr_key_d    = do_wr && (state != S_IN_TEXT);
    wr_idx_d    = do_wr ? cnt : '0;
    wr_data_d   = do_wr ? digit : 4'd0;
    core_mode_d = (state_d == S_DEC_RUN);
    locked_d    = (state_d == S_LOCKED);
  end

endmodule

// File: tb/tb_lea_cu_gen.sv
// Directed self-checking bench for lea_cu_gen with default parameters.
module tb_lea_cu_gen;

  logic       clk = 1'b0;
  logic       rst, star, sharp, digit_valid, key_match, core_done;
  logic [3:0] digit;
  logic [2:0] lcd_addr;
  logic       chk_text, chk_key, star_out, sharp_out, wr_text, wr_key;
  logic [3:0] wr_idx, wr_data;
  logic       core_start, core_mode, locked;
  logic [19:0] outs;
  int n_cmp = 0;
  int n_bad = 0;

  lea_cu_gen dut (
    .clk(clk), .rst(rst), .star(star), .sharp(sharp),
    .digit_valid(digit_valid), .digit(digit), .key_match(key_match),
    .core_done(core_done), .LCD_addr(lcd_addr), .chk_text(chk_text),
    .chk_key(chk_key), .star_out(star_out), .sharp_out(sharp_out),
    .wr_text(wr_text), .wr_key(wr_key), .wr_idx(wr_idx), .wr_data(wr_data),
    .core_start(core_start), .core_mode(core_mode), .locked(locked)
  );

  assign outs = {lcd_addr, chk_text, chk_key, star_out, sharp_out, wr_text, wr_key,
                 wr_idx, wr_data, core_start, core_mode, locked};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; star = 1'b0; sharp = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    key_match = 1'b0; core_done = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic press(input logic s, input logic h);
    star = s; sharp = h;
    tick;
    star = 1'b0; sharp = 1'b0;
    tick;
  endtask

  task automatic enter(input int n);
    for (int i = 0; i < n; i++) begin
      digit_valid = 1'b1;
      digit = 4'(i % 10);
      tick;
    end
    digit_valid = 1'b0;
  endtask

  task automatic pulse_done;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
  endtask

  task automatic nav_start_to_key_full;
    press(1'b1, 1'b0); enter(8); press(1'b0, 1'b1); enter(8);
  endtask

  task automatic nav_key_full_to_dec;
    press(1'b0, 1'b1); pulse_done; press(1'b1, 1'b0); press(1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0; star = 1'b0; sharp = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    key_match = 1'b0; core_done = 1'b0;
    #2;
    n_cmp++;
    if (outs !== 20'd0) begin n_bad++; $display("FAIL reset_outs got %h want 0", outs); end
    tick; rst = 1'b1; tick; tick;
    n_cmp++;
    if (outs !== 20'd0) begin n_bad++; $display("FAIL after_reset_idle got %h want 0", outs); end
  endtask

  task automatic test_text_entry;
    star = 1'b1; tick;
    n_cmp++;
    if ({lcd_addr, star_out} !== {3'd1, 1'b1}) begin
      n_bad++; $display("FAIL start_to_in_text lcd=%0d star_out=%b want 1/1", lcd_addr, star_out);
    end
    star = 1'b0; tick;
    n_cmp++;
    if (star_out !== 1'b0) begin n_bad++; $display("FAIL star_out_one_cycle got %b want 0", star_out); end
    for (int i = 0; i < 8; i++) begin
      digit_valid = 1'b1; digit = 4'(9 - i); tick;
      n_cmp++;
      if ({wr_text, wr_key, wr_idx, wr_data, chk_text} !== {1'b1, 1'b0, 4'(i), 4'(9 - i), (i == 7)}) begin
        n_bad++;
        $display("FAIL text_write_%0d got wr=%b idx=%0d data=%0d chk=%b want 1/%0d/%0d/%b",
                 i, wr_text, wr_idx, wr_data, chk_text, i, 9 - i, (i == 7));
      end
    end
    tick;
    n_cmp++;
    if ({wr_text, chk_text} !== 2'b01) begin
      n_bad++; $display("FAIL ninth_digit_ignored wr=%b chk=%b want 0/1", wr_text, chk_text);
    end
    digit_valid = 1'b0;
    star = 1'b1; tick; star = 1'b0;
    n_cmp++;
    if ({lcd_addr, chk_text} !== {3'd1, 1'b0}) begin
      n_bad++; $display("FAIL star_clears_text lcd=%0d chk=%b want 1/0", lcd_addr, chk_text);
    end
    tick;
    digit_valid = 1'b1; digit = 4'd3; tick; digit_valid = 1'b0;
    n_cmp++;
    if ({wr_text, wr_idx, wr_data} !== {1'b1, 4'd0, 4'd3}) begin
      n_bad++; $display("FAIL restart_idx wr=%b idx=%0d data=%0d want 1/0/3", wr_text, wr_idx, wr_data);
    end
    enter(7);
    sharp = 1'b1; tick; sharp = 1'b0;
    n_cmp++;
    if ({lcd_addr, chk_text, chk_key} !== {3'd2, 2'b00}) begin
      n_bad++; $display("FAIL text_to_in_key lcd=%0d chk_text=%b chk_key=%b want 2/0/0", lcd_addr, chk_text, chk_key);
    end
    tick;
  endtask

  task automatic test_enc_flow;
    enter(5);
    sharp = 1'b1; tick; sharp = 1'b0;
    n_cmp++;
    if ({lcd_addr, core_start, chk_key} !== {3'd2, 2'b00}) begin
      n_bad++; $display("FAIL short_key_sharp lcd=%0d start=%b chk=%b want 2/0/0", lcd_addr, core_start, chk_key);
    end
    tick;
    digit_valid = 1'b1; digit = 4'd6; tick; digit_valid = 1'b0;
    n_cmp++;
    if ({wr_key, wr_idx, wr_data} !== {1'b1, 4'd5, 4'd6}) begin
      n_bad++; $display("FAIL key_write_idx5 wr=%b idx=%0d data=%0d want 1/5/6", wr_key, wr_idx, wr_data);
    end
    enter(2);
    n_cmp++;
    if (chk_key !== 1'b1) begin n_bad++; $display("FAIL key_full got %b want 1", chk_key); end
    sharp = 1'b1; tick; sharp = 1'b0;
    n_cmp++;
    if ({lcd_addr, core_start, core_mode, chk_key} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL enc_start lcd=%0d start=%b mode=%b chk=%b want 2/1/0/0", lcd_addr, core_start, core_mode, chk_key);
    end
    tick;
    n_cmp++;
    if (core_start !== 1'b0) begin n_bad++; $display("FAIL enc_start_pulse got %b want 0", core_start); end
    pulse_done;
    n_cmp++;
    if (lcd_addr !== 3'd3) begin n_bad++; $display("FAIL enc_done lcd=%0d want 3", lcd_addr); end
    pulse_done;
    n_cmp++;
    if (lcd_addr !== 3'd3) begin n_bad++; $display("FAIL stray_done_enc_ok lcd=%0d want 3", lcd_addr); end
    press(1'b1, 1'b0);
    n_cmp++;
    if (lcd_addr !== 3'd4) begin n_bad++; $display("FAIL show_ct lcd=%0d want 4", lcd_addr); end
    press(1'b1, 1'b0);
    n_cmp++;
    if ({lcd_addr, chk_key} !== {3'd5, 1'b0}) begin
      n_bad++; $display("FAIL in_key_dec lcd=%0d chk=%b want 5/0", lcd_addr, chk_key);
    end
  endtask

  task automatic test_decrypt;
    enter(8);
    key_match = 1'b0; sharp = 1'b1; tick; sharp = 1'b0;
    n_cmp++;
    if ({lcd_addr, chk_key, core_start} !== {3'd5, 2'b00}) begin
      n_bad++; $display("FAIL wrong_key_once lcd=%0d chk=%b start=%b want 5/0/0", lcd_addr, chk_key, core_start);
    end
    tick;
    enter(8);
    key_match = 1'b1; sharp = 1'b1; tick; sharp = 1'b0; key_match = 1'b0;
    n_cmp++;
    if ({lcd_addr, core_start, core_mode} !== {3'd5, 2'b11}) begin
      n_bad++; $display("FAIL dec_start lcd=%0d start=%b mode=%b want 5/1/1", lcd_addr, core_start, core_mode);
    end
    tick; tick;
    n_cmp++;
    if ({core_start, core_mode} !== 2'b01) begin
      n_bad++; $display("FAIL dec_mode_held start=%b mode=%b want 0/1", core_start, core_mode);
    end
    pulse_done;
    n_cmp++;
    if ({lcd_addr, core_mode} !== {3'd6, 1'b0}) begin
      n_bad++; $display("FAIL dec_done lcd=%0d mode=%b want 6/0", lcd_addr, core_mode);
    end
    press(1'b1, 1'b0);
    n_cmp++;
    if (lcd_addr !== 3'd0) begin n_bad++; $display("FAIL dec_ok_to_start lcd=%0d want 0", lcd_addr); end
    // one wrong key was used earlier; two more must not lock once tries are cleared
    nav_start_to_key_full; nav_key_full_to_dec;
    for (int k = 0; k < 2; k++) begin
      enter(8); press(1'b0, 1'b1);
    end
    n_cmp++;
    if ({lcd_addr, locked} !== {3'd5, 1'b0}) begin
      n_bad++; $display("FAIL tries_cleared lcd=%0d locked=%b want 5/0", lcd_addr, locked);
    end
  endtask

  task automatic test_lockout;
    do_reset; nav_start_to_key_full; nav_key_full_to_dec;
    key_match = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enter(8);
      sharp = 1'b1; tick; sharp = 1'b0;
      n_cmp++;
      if (lcd_addr !== ((k < 2) ? 3'd5 : 3'd7)) begin
        n_bad++; $display("FAIL wrong_key_%0d lcd=%0d want %0d", k, lcd_addr, (k < 2) ? 5 : 7);
      end
      tick;
    end
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL locked got %b want 1", locked); end
    press(1'b1, 1'b0); press(1'b0, 1'b1); pulse_done;
    digit_valid = 1'b1; tick; digit_valid = 1'b0;
    n_cmp++;
    if ({lcd_addr, locked, wr_key, core_start} !== {3'd7, 1'b1, 2'b00}) begin
      n_bad++; $display("FAIL locked_ignores lcd=%0d locked=%b wr=%b start=%b want 7/1/0/0", lcd_addr, locked, wr_key, core_start);
    end
    do_reset;
    n_cmp++;
    if ({lcd_addr, locked} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL unlock_by_reset lcd=%0d locked=%b want 0/0", lcd_addr, locked);
    end
  endtask

  task automatic test_simultaneous;
    do_reset; nav_start_to_key_full;
    star = 1'b1; sharp = 1'b1; tick; star = 1'b0; sharp = 1'b0;
    n_cmp++;
    if ({lcd_addr, chk_key, core_start, star_out, sharp_out} !== {3'd2, 1'b1, 1'b0, 2'b11}) begin
      n_bad++; $display("FAIL star_sharp_same lcd=%0d chk=%b start=%b so=%b ho=%b want 2/1/0/1/1",
                        lcd_addr, chk_key, core_start, star_out, sharp_out);
    end
    tick;
    star = 1'b1; digit_valid = 1'b1; tick; star = 1'b0; digit_valid = 1'b0;
    n_cmp++;
    if ({wr_key, chk_key, lcd_addr} !== {2'b00, 3'd2}) begin
      n_bad++; $display("FAIL digit_with_star wr=%b chk=%b lcd=%0d want 0/0/2", wr_key, chk_key, lcd_addr);
    end
    tick;
    enter(7);
    sharp = 1'b1; digit_valid = 1'b1; digit = 4'd9; tick; sharp = 1'b0; digit_valid = 1'b0;
    n_cmp++;
    if ({wr_key, lcd_addr} !== {1'b0, 3'd2}) begin
      n_bad++; $display("FAIL digit_with_sharp wr=%b lcd=%0d want 0/2", wr_key, lcd_addr);
    end
    tick;
    digit_valid = 1'b1; digit = 4'd4; tick; digit_valid = 1'b0;
    n_cmp++;
    if ({wr_key, wr_idx, chk_key} !== {1'b1, 4'd7, 1'b1}) begin
      n_bad++; $display("FAIL digit_discarded wr=%b idx=%0d chk=%b want 1/7/1", wr_key, wr_idx, chk_key);
    end
    sharp = 1'b1; tick; sharp = 1'b0;
    n_cmp++;
    if ({lcd_addr, core_start} !== {3'd2, 1'b1}) begin
      n_bad++; $display("FAIL enc_start_before_rst lcd=%0d start=%b want 2/1", lcd_addr, core_start);
    end
    rst = 1'b0; #2;
    n_cmp++;
    if (outs !== 20'd0) begin n_bad++; $display("FAIL async_reset_enc_run got %h want 0", outs); end
    tick; rst = 1'b1; tick;
  endtask

  task automatic test_reset_held_star;
    rst = 1'b0; star = 1'b1; tick; tick;
    rst = 1'b1; tick; tick; tick;
    n_cmp++;
    if ({lcd_addr, star_out} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL held_star_no_edge lcd=%0d so=%b want 0/0", lcd_addr, star_out);
    end
    star = 1'b0; tick;
    star = 1'b1; tick; star = 1'b0;
    n_cmp++;
    if ({lcd_addr, star_out} !== {3'd1, 1'b1}) begin
      n_bad++; $display("FAIL star_repress lcd=%0d so=%b want 1/1", lcd_addr, star_out);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_text_entry;
    test_enc_flow;
    test_decrypt;
    test_lockout;
    test_simultaneous;
    test_reset_held_star;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
